// File: rtl/signal_register_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : signal_register_pkg
//  Purpose  : Shared types and helpers for the multi-channel signal capture
//             block: FSM state encoding, capture-depth and counter-width
//             helpers, and the overrun counter width.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package signal_register_pkg;

   // Capture framing states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      FULL = 2'd2
   } state_t;

   // Overrun counter width (saturates at all-ones)
   localparam int OVR_W = 8;

   // Shift-register depth of one channel
   function automatic int depth(input int samples, input int osf);
      return samples * osf;
   endfunction

   // Width needed to hold a count from 0 up to and including d
   function automatic int cnt_width(input int d);
      return $clog2(d + 1);
   endfunction

endpackage : signal_register_pkg
`default_nettype wire

// File: rtl/sig_reg_channel.sv
`default_nettype none
// ============================================================================
//  Module   : sig_reg_channel
//  Purpose  : One DEPTH-bit serial-in shift register. New bits enter at the
//             MSB and move towards the LSB, so the oldest bit sits at bit 0.
//  Ports    : Clk      - rising-edge clock
//             Reset    - asynchronous active-low reset (clears register)
//             Clear    - synchronous clear, dominates Shift_En
//             Shift_En - shift one bit in this cycle
//             Data_In  - serial input bit
//             Data_Out - DEPTH-bit register contents
//  Revision : 1.0 - initial release
// ============================================================================
module sig_reg_channel #(
   parameter int DEPTH = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Clear,
   input  logic             Shift_En,
   input  logic             Data_In,
   output logic [DEPTH-1:0] Data_Out
);

   logic [DEPTH-1:0] r_sreg;

   // A single-bit register has no upper slice to shift from
   if (DEPTH > 1) begin : g_shift_wide
      always_ff @(posedge Clk or negedge Reset) begin
         if (!Reset) begin
            r_sreg <= '0;
         end else if (Clear) begin
            r_sreg <= '0;
         end else if (Shift_En) begin
            r_sreg <= {Data_In, r_sreg[DEPTH-1:1]};
         end
      end
   end else begin : g_shift_one
      always_ff @(posedge Clk or negedge Reset) begin
         if (!Reset) begin
            r_sreg <= '0;
         end else if (Clear) begin
            r_sreg <= '0;
         end else if (Shift_En) begin
            r_sreg <= Data_In;
         end
      end
   end

   assign Data_Out = r_sreg;

endmodule : sig_reg_channel
`default_nettype wire

// File: rtl/multi_channel_signal_capture.sv
`default_nettype none
// ============================================================================
//  Module   : multi_channel_signal_capture
//  Purpose  : Captures CHANNELS parallel oversampled 1-bit streams into
//             DEPTH = SAMPLES*OSF shift registers. An IDLE/FILL/FULL FSM
//             frames one capture, freezes it when full and holds it until
//             the downstream consumer acknowledges.
//  Config   : SIGREG_OVERRUN_EN - when defined, adds the Overrun port, a
//             saturating count of Shift strobes seen while FULL.
//  Ports    : Clk         - rising-edge clock
//             Reset       - asynchronous active-low reset
//             Start       - begin / restart a capture frame
//             Shift       - sample strobe, accepted only in FILL
//             Data_In     - one serial bit per channel
//             Ack         - consumer has read the frozen frame
//             Data_Out    - channel c at [c*DEPTH +: DEPTH]
//             Busy        - high while filling
//             Frame_Valid - high while frozen (Data_Out stable)
//             Fill_Count  - shifts accepted in the current frame
//             Overrun     - (SIGREG_OVERRUN_EN only) shifts ignored in FULL
//  Revision : 1.0 - initial release
// ============================================================================
module multi_channel_signal_capture
   import signal_register_pkg::*;
#(
   parameter  int CHANNELS       = 2,
   parameter  int SAMPLES        = 128,
   parameter  int OSF            = 8,
   parameter  int CLEAR_ON_START = 1,
   localparam int DEPTH          = depth(SAMPLES, OSF),
   localparam int CW             = cnt_width(DEPTH)
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic                      Start,
   input  logic                      Shift,
   input  logic [CHANNELS-1:0]       Data_In,
   input  logic                      Ack,
   output logic [CHANNELS*DEPTH-1:0] Data_Out,
   output logic                      Busy,
   output logic                      Frame_Valid,
   output logic [CW-1:0]             Fill_Count
`ifdef SIGREG_OVERRUN_EN
   ,
   output logic [OVR_W-1:0]          Overrun
`endif
);

   localparam logic [CW-1:0] c_LAST_CNT = CW'(DEPTH - 1);

   state_t        r_state;
   state_t        w_next_state;
   logic          w_start_acc;   // Start taken this cycle (restart or new frame)
   logic          w_shift_acc;   // Shift taken this cycle
   logic          w_clear;
   logic [CW-1:0] r_fill;
   logic          r_busy;
   logic          r_frame_valid;

   // ------------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------------
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ------------------------------------------------------------------------
   // Next state and per-cycle actions. Start always wins over a same-cycle
   // Shift, so a restart never carries a stray sample into the new frame.
   // ------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      w_start_acc  = 1'b0;
      w_shift_acc  = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (Start) begin
               w_next_state = FILL;
               w_start_acc  = 1'b1;
            end
         end
         FILL: begin
            if (Start) begin
               w_start_acc = 1'b1;
            end else if (Shift) begin
               w_shift_acc = 1'b1;
               if (r_fill == c_LAST_CNT) begin
                  w_next_state = FULL;
               end
            end
         end
         FULL: begin
            // Start alone is ignored: the frame stays frozen until Ack
            if (Ack) begin
               if (Start) begin
                  w_next_state = FILL;
                  w_start_acc  = 1'b1;
               end else begin
                  w_next_state = IDLE;
               end
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   assign w_clear = w_start_acc && (CLEAR_ON_START != 0);

   // ------------------------------------------------------------------------
   // Registered status and fill counter. Status follows the next state so it
   // is visible in the cycle right after the transition edge.
   // ------------------------------------------------------------------------
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_fill        <= '0;
         r_busy        <= 1'b0;
         r_frame_valid <= 1'b0;
      end else begin
         r_busy        <= (w_next_state == FILL);
         r_frame_valid <= (w_next_state == FULL);
         if (w_start_acc) begin
            r_fill <= '0;
         end else if (w_shift_acc) begin
            // Shifts are only accepted below DEPTH, so this cannot wrap
            r_fill <= r_fill + CW'(1);
         end
      end
   end

   assign Busy        = r_busy;
   assign Frame_Valid = r_frame_valid;
   assign Fill_Count  = r_fill;

   // ------------------------------------------------------------------------
   // Per-channel shift registers
   // ------------------------------------------------------------------------
   for (genvar gc = 0; gc < CHANNELS; gc++) begin : g_channel
      sig_reg_channel #(
         .DEPTH    (DEPTH)
      ) u_chan (
         .Clk      (Clk),
         .Reset    (Reset),
         .Clear    (w_clear),
         .Shift_En (w_shift_acc),
         .Data_In  (Data_In[gc]),
         .Data_Out (Data_Out[gc*DEPTH +: DEPTH])
      );
   end

`ifdef SIGREG_OVERRUN_EN
   // ------------------------------------------------------------------------
   // Overrun: strobes the consumer missed while the frame was frozen
   // ------------------------------------------------------------------------
   logic [OVR_W-1:0] r_overrun;
   logic             w_ovr_evt;

   assign w_ovr_evt = (r_state == FULL) && Shift;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_overrun <= '0;
      end else if (w_start_acc) begin
         r_overrun <= '0;
      end else if (w_ovr_evt && (r_overrun != {OVR_W{1'b1}})) begin
         r_overrun <= r_overrun + OVR_W'(1);
      end
   end

   assign Overrun = r_overrun;
`endif

endmodule : multi_channel_signal_capture
`default_nettype wire
